serial_topk_peak_finder: RTL and testbench

//  Streaming peak finder for FFT magnitude frames. Consumes one (index, magnitude) bin per valid

---
 rtl/serial_topk_peak_finder.sv | 170 +++++++++++++++++
 tb/tb_serial_topk_peak_finder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_topk_peak_finder.sv
// Streaming peak finder: finds local maxima in a bin stream and publishes the NUM_PEAKS largest.
// Optional macro PEAK_THRESH_EN adds a per-bin threshold input (thresh_i).
module serial_topk_peak_finder #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned INDEX_W   = 12,
    parameter int unsigned NUM_PEAKS = 4,
    parameter int unsigned MIN_INDEX = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_i,
    input  logic                         start_i,
    input  logic                         last_i,
    input  logic [DATA_W-1:0]            data_in_i,
`ifdef PEAK_THRESH_EN
    input  logic [DATA_W-1:0]            thresh_i,
`endif
    input  logic [INDEX_W-1:0]           index_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [3:0]                   peak_count_o,
    output logic [NUM_PEAKS*INDEX_W-1:0] peak_index_o,
    output logic [NUM_PEAKS*DATA_W-1:0]  peak_mag_o
);

    typedef enum logic [1:0] {StIdle, StScan, StFlush, StDone} state_e;

    state_e state_q, state_d;
    logic   restart_q, restart_d;
    logic   reflush_q, reflush_d;
    logic   busy_q, busy_d;
    logic   done_q;

    logic [DATA_W-1:0]  prev_mag_q, cur_mag_q;
    logic [INDEX_W-1:0] cur_idx_q;
    logic [DATA_W-1:0]  pend_mag_q, pend_mag_d;
    logic [INDEX_W-1:0] pend_idx_q;

    logic [NUM_PEAKS-1:0][DATA_W-1:0]  list_mag_q, list_mag_d, ins_mag, out_mag_q;
    logic [NUM_PEAKS-1:0][INDEX_W-1:0] list_idx_q, list_idx_d, ins_idx, out_idx_q;
    logic [3:0]                        ins_cnt, count_q;

    logic               start_bin, accept_bin, eval_en, cand, thr_ok;
    logic [DATA_W-1:0]  next_mag, carry_mag;
    logic [INDEX_W-1:0] carry_idx;

`ifdef PEAK_THRESH_EN
    logic [DATA_W-1:0] cur_thr_q;
    assign thr_ok = cur_mag_q > cur_thr_q;
`else
    assign thr_ok = 1'b1;
`endif

    // A non-start bin advances the window in SCAN, or in DONE when a new frame began during FLUSH.
    always_comb begin
        start_bin  = valid_i & start_i;
        accept_bin = valid_i & ~start_i &
                     ((state_q == StScan) | ((state_q == StDone) & restart_q));
        eval_en    = (state_q == StFlush) | accept_bin;
        next_mag   = (state_q == StFlush) ? '0 : data_in_i;
        cand       = eval_en & (prev_mag_q < cur_mag_q) & (cur_mag_q >= next_mag) &
                     (cur_idx_q >= INDEX_W'(MIN_INDEX)) & (cur_mag_q != '0) & thr_ok;
        pend_mag_d = cand ? cur_mag_q : '0;
    end

    // Pending magnitude of 0 means no insertion; empty slots hold 0 so any candidate beats them.
    always_comb begin
        ins_mag   = list_mag_q;
        ins_idx   = list_idx_q;
        carry_mag = pend_mag_q;
        carry_idx = pend_idx_q;
        ins_cnt   = '0;
        for (int k = 0; k < NUM_PEAKS; k++) begin
            if (pend_mag_q > list_mag_q[k]) begin
                ins_mag[k] = carry_mag;
                ins_idx[k] = carry_idx;
                carry_mag  = list_mag_q[k];
                carry_idx  = list_idx_q[k];
            end
            ins_cnt = ins_cnt + {3'b000, (ins_mag[k] != '0)};
        end
        if ((start_bin && (state_q != StFlush)) || (state_q == StDone)) begin
            list_mag_d = '0;
            list_idx_d = '0;
        end else begin
            list_mag_d = ins_mag;
            list_idx_d = ins_idx;
        end
    end

    always_comb begin
        state_d   = state_q;
        restart_d = 1'b0;
        reflush_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_bin) state_d = last_i ? StFlush : StScan;
            end
            StScan: begin
                if (valid_i && last_i) state_d = StFlush;
            end
            StFlush: begin
                state_d   = StDone;
                restart_d = start_bin & ~last_i;
                reflush_d = start_bin & last_i;
            end
            StDone: begin
                if (start_bin)      state_d = last_i ? StFlush : StScan;
                else if (reflush_q) state_d = StFlush;
                else if (restart_q) state_d = (valid_i && last_i) ? StFlush : StScan;
                else                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StScan) | (state_d == StFlush) | restart_d | reflush_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            restart_q  <= 1'b0;
            reflush_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            prev_mag_q <= '0;
            cur_mag_q  <= '0;
            cur_idx_q  <= '0;
`ifdef PEAK_THRESH_EN
            cur_thr_q  <= '0;
`endif
            pend_mag_q <= '0;
            pend_idx_q <= '0;
            list_mag_q <= '0;
            list_idx_q <= '0;
            out_mag_q  <= '0;
            out_idx_q  <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            restart_q  <= restart_d;
            reflush_q  <= reflush_d;
            busy_q     <= busy_d;
            done_q     <= (state_q == StDone);
            pend_mag_q <= pend_mag_d;
            pend_idx_q <= cur_idx_q;
            list_mag_q <= list_mag_d;
            list_idx_q <= list_idx_d;
            if (start_bin || accept_bin) begin
                prev_mag_q <= start_bin ? '0 : cur_mag_q;
                cur_mag_q  <= data_in_i;
                cur_idx_q  <= index_i;
`ifdef PEAK_THRESH_EN
                cur_thr_q  <= thresh_i;
`endif
            end
            if (state_q == StDone) begin
                out_mag_q <= ins_mag;
                out_idx_q <= ins_idx;
                count_q   <= ins_cnt;
            end
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign peak_count_o = count_q;
    assign peak_index_o = out_idx_q;
    assign peak_mag_o   = out_mag_q;

endmodule

// File: tb/tb_serial_topk_peak_finder.sv
// Randomized and directed bench for serial_topk_peak_finder against a frame-level reference model.
`timescale 1ns/1ps
module tb_serial_topk_peak_finder;
    localparam int DW   = 32;
    localparam int IW   = 12;
    localparam int NP   = 4;
    localparam int MINI = 1;
    localparam int CW   = NP * DW;
`ifdef PEAK_THRESH_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0, start = 1'b0, last = 1'b0;
    logic [DW-1:0] din = '0, thr = '0;
    logic [IW-1:0] idx = '0;
    logic          busy, done;
    logic [3:0]    pcount;
    logic [NP*IW-1:0] pidx;
    logic [NP*DW-1:0] pmag;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;

    serial_topk_peak_finder #(
        .DATA_W(DW), .INDEX_W(IW), .NUM_PEAKS(NP), .MIN_INDEX(MINI)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .valid_i(valid),
        .start_i(start),
        .last_i(last),
        .data_in_i(din),
`ifdef PEAK_THRESH_EN
        .thresh_i(thr),
`endif
        .index_i(idx),
        .busy_o(busy),
        .done_o(done),
        .peak_count_o(pcount),
        .peak_index_o(pidx),
        .peak_mag_o(pmag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: collects each frame's bins, then picks peaks with plain arithmetic.
    typedef struct {
        int               cnt;
        int               n;
        logic [NP*IW-1:0] pi;
        logic [NP*DW-1:0] pm;
    } pub_t;

    logic [DW-1:0] fm[$];
    logic [IW-1:0] fi[$];
    logic [DW-1:0] ft[$];
    pub_t          pq[$];
    bit            in_frame = 1'b0;
    logic          exp_done = 1'b0, exp_busy = 1'b0;
    logic [3:0]    exp_cnt = '0;
    logic [NP*IW-1:0] exp_idx = '0;
    logic [NP*DW-1:0] exp_mag = '0;

    function automatic pub_t evaluate_frame();
        pub_t          p;
        logic [DW-1:0] cm[$];
        logic [IW-1:0] ci[$];
        bit            used[$];
        logic [DW-1:0] pv, nx;
        int            n, best;
        n = fm.size();
        p.cnt = 2; p.n = 0; p.pi = '0; p.pm = '0;
        for (int i = 0; i < n; i++) begin
            pv = '0;
            nx = '0;
            if (i > 0) pv = fm[i-1];
            if (i < n - 1) nx = fm[i+1];
            if (pv < fm[i] && fm[i] >= nx && fi[i] >= IW'(MINI) && fm[i] != '0 && fm[i] > ft[i]) begin
                cm.push_back(fm[i]);
                ci.push_back(fi[i]);
                used.push_back(1'b0);
            end
        end
        for (int s = 0; s < NP; s++) begin
            best = -1;
            for (int j = 0; j < cm.size(); j++)
                if (!used[j] && (best < 0 || cm[j] > cm[best])) best = j;
            if (best >= 0) begin
                used[best] = 1'b1;
                p.pi[s*IW +: IW] = ci[best];
                p.pm[s*DW +: DW] = cm[best];
                p.n++;
            end
        end
        return p;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            in_frame = 1'b0;
            fm.delete(); fi.delete(); ft.delete(); pq.delete();
            exp_done = 1'b0; exp_busy = 1'b0; exp_cnt = '0; exp_idx = '0; exp_mag = '0;
        end else begin
            exp_done = 1'b0;
            for (int q = 0; q < pq.size(); q++) pq[q].cnt = pq[q].cnt - 1;
            while (pq.size() > 0 && pq[0].cnt <= 0) begin
                exp_done = 1'b1;
                exp_cnt  = 4'(pq[0].n);
                exp_idx  = pq[0].pi;
                exp_mag  = pq[0].pm;
                void'(pq.pop_front());
            end
            if (valid) begin
                if (start) begin
                    fm.delete(); fi.delete(); ft.delete();
                    in_frame = 1'b1;
                end
                if (in_frame) begin
                    fm.push_back(din);
                    fi.push_back(idx);
                    ft.push_back(thr & {DW{THR_EN}});
                    if (last) begin
                        pq.push_back(evaluate_frame());
                        in_frame = 1'b0;
                    end
                end
            end
            exp_busy = in_frame;
            for (int q = 0; q < pq.size(); q++) if (pq[q].cnt == 2) exp_busy = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) done_pulses++;
        check_eq("done", CW'(done), CW'(exp_done));
        check_eq("busy", CW'(busy), CW'(exp_busy));
        check_eq("peak_count", CW'(pcount), CW'(exp_cnt));
        check_eq("peak_index", CW'(pidx), CW'(exp_idx));
        check_eq("peak_mag", pmag, exp_mag);
    end

    task automatic drive(input bit v, input bit s, input bit l, input logic [DW-1:0] m,
                         input logic [IW-1:0] i, input logic [DW-1:0] t);
        valid = v; start = s; last = l; din = m; idx = i; thr = t;
        @(posedge clk);
        #1;
        valid = 1'b0; start = 1'b0; last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic send_frame(input logic [DW-1:0] m[$], input bit toggle, input logic [DW-1:0] t);
        for (int i = 0; i < m.size(); i++) begin
            drive(1'b1, i == 0, i == m.size() - 1, m[i], IW'(i), t);
            if (toggle && i != m.size() - 1) drive(1'b0, 1'b0, 1'b0, '0, '0, t);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_slots(input string tag, input int n, input int ei[NP], input int em[NP]);
        check_eq({tag, " count"}, CW'(pcount), CW'(n));
        for (int k = 0; k < NP; k++) begin
            check_eq($sformatf("%s idx%0d", tag, k), CW'(pidx[k*IW +: IW]), CW'(ei[k]));
            check_eq($sformatf("%s mag%0d", tag, k), CW'(pmag[k*DW +: DW]), CW'(em[k]));
        end
    endtask

    logic [DW-1:0] t2[$] = '{0, 10, 3, 50, 2, 50, 1, 20};
    logic [DW-1:0] t3[$] = '{0, 60, 0, 10, 0, 70, 0, 30, 0, 80, 0, 20, 0};
    int t2_i[NP] = '{3, 5, 7, 1};
    int t2_m[NP] = '{50, 50, 20, 10};
    int t3_i[NP] = '{9, 5, 1, 7};
    int t3_m[NP] = '{80, 70, 60, 30};
    int t1_i[NP] = '{293, 0, 0, 0};
    int t1_m[NP] = '{4095, 0, 0, 0};
    int th_i[NP] = '{3, 5, 0, 0};
    int th_m[NP] = '{50, 50, 0, 0};

    initial begin
        logic [DW-1:0] ramp[$];
        logic [NP*DW-1:0] t3_packed;
        int lat, p0, len, gap;
        bit s, l;
        logic [DW-1:0] m;
        logic [IW-1:0] ix;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset busy", CW'(busy), CW'(0));
        check_eq("reset done", CW'(done), CW'(0));
        check_eq("reset count", CW'(pcount), CW'(0));
        check_eq("reset mag", pmag, CW'(0));
        rst_n = 1'b1;
        idle(2);

        for (int v = 0; v <= 4088; v += 14) ramp.push_back(DW'(v));
        for (int v = 4095; v >= 0; v -= 28) ramp.push_back(DW'(v));
        send_frame(ramp, 1'b0, '0);
        wait_done(lat);
        check_eq("t1 latency", CW'(lat), CW'(3));
        check_slots("t1", 1, t1_i, t1_m);
        idle(3);

        send_frame(t2, 1'b0, '0);
        wait_done(lat);
        check_eq("t2 latency", CW'(lat), CW'(3));
        check_slots("t2", 4, t2_i, t2_m);
        idle(2);

        send_frame(t2, 1'b1, '0);
        wait_done(lat);
        check_eq("t4 latency", CW'(lat), CW'(3));
        check_slots("t4", 4, t2_i, t2_m);
        idle(2);

        send_frame(t3, 1'b0, '0);
        wait_done(lat);
        check_slots("t3", 4, t3_i, t3_m);
        idle(2);

        t3_packed = pmag;
        p0 = done_pulses;
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 1'b0, t3[i], IW'(i), '0);
        send_frame(t2, 1'b0, '0);
        check_eq("t5 held mag", pmag, CW'({32'd30, 32'd60, 32'd70, 32'd80}));
        wait_done(lat);
        check_eq("t5 latency", CW'(lat), CW'(3));
        check_slots("t5", 4, t2_i, t2_m);
        idle(4);
        check_eq("t5 done pulses", CW'(done_pulses - p0), CW'(1));
        check_eq("t5 prior frame", t3_packed, CW'({32'd30, 32'd60, 32'd70, 32'd80}));

        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 1'b0, t2[i], IW'(i), '0);
        rst_n = 1'b0;
        #1;
        check_eq("t6 busy", CW'(busy), CW'(0));
        check_eq("t6 count", CW'(pcount), CW'(0));
        check_eq("t6 index", CW'(pidx), CW'(0));
        check_eq("t6 mag", pmag, CW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);

        if (THR_EN) begin
            send_frame(t2, 1'b0, DW'(40));
            wait_done(lat);
            check_slots("thresh", 2, th_i, th_m);
            idle(2);
        end

        // Start of the next frame lands 1..4 cycles after a last, covering FLUSH and DONE restarts.
        for (int f = 0; f < 80; f++) begin
            len = $urandom_range(1, 16);
            gap = $urandom_range(0, 3);
            if (gap == 0 && len == 1) len = 2;
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 3) == 0)
                    drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom_range(1, 9)), '0, '0);
                else
                    idle(1);
            end
            for (int i = 0; i < len; i++) begin
                if (i > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                s = (i == 0) || (i < len - 1 && $urandom_range(0, 15) == 0);
                l = (i == len - 1);
                m = ($urandom_range(0, 19) == 0) ? DW'($urandom) : DW'($urandom_range(0, 12));
                ix = ($urandom_range(0, 9) == 0) ? IW'($urandom) : IW'(i);
                drive(1'b1, s, l, m, ix, DW'($urandom_range(0, 6)));
            end
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
